// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: queues {d1,d0,mark} requests and sends continuous
// 3-bit frames (d1, d0, parity) MSB-first, filling gaps with idle 000 frames.
module serial_frame_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_data,
    input  logic             in_mark,
    output logic             ser_out,
    output logic             frame_start,
    output logic [1:0]       bit_idx,
    output logic             idle_frame,
    output logic [LW-1:0]    fifo_level,
    output logic [CNT_W-1:0] sent_count
);

    logic [1:0]       bit_idx_q;
    logic [2:0]       frm_q;
    logic             idle_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [CNT_W-1:0] sent_q;
    logic [2:0]       mem_q [DEPTH];

    logic       load;
    logic       empty;
    logic       push;
    logic       pop;
    logic [2:0] head;

    assign load  = (bit_idx_q == 2'd2);
    assign empty = (level_q == '0);
    assign push  = in_valid && in_ready;
    // Pop only uses the level before this edge, so a same-edge push is never bypassed.
    assign pop   = load && !empty;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx_q <= 2'd0;
            frm_q     <= 3'b000;
            idle_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            sent_q    <= '0;
        end else begin
            bit_idx_q <= load ? 2'd0 : bit_idx_q + 2'd1;
            level_q   <= level_d;
            if (push) begin
                wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
            end
            if (load) begin
                if (!empty) begin
                    frm_q    <= {head[2], head[1], ^head};
                    idle_q   <= 1'b0;
                    sent_q   <= sent_q + CNT_W'(1);
                    rd_ptr_q <= AW'(rd_ptr_q + AW'(1));
                end else begin
                    frm_q  <= 3'b000;
                    idle_q <= 1'b1;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; the level and pointers alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_data, in_mark};
        end
    end

    assign in_ready    = (level_q != LW'(DEPTH));
    assign ser_out     = frm_q[2'd2 - bit_idx_q];
    assign frame_start = (bit_idx_q == 2'd0);
    assign bit_idx     = bit_idx_q;
    assign idle_frame  = idle_q;
    assign fifo_level  = level_q;
    assign sent_count  = sent_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: hand-computed frames, FIFO levels,
// parity-detector flags, full/hold-off, reset abort and counter wrap.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_mark;
    logic       ser_out;
    logic       frame_start;
    logic [1:0] bit_idx;
    logic       idle_frame;
    logic [2:0] fifo_level;
    logic [7:0] sent_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx = 0;

    serial_frame_tx #(.DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mark     (in_mark),
        .ser_out     (ser_out),
        .frame_start (frame_start),
        .bit_idx     (bit_idx),
        .idle_frame  (idle_frame),
        .fifo_level  (fifo_level),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        exp_idx = (exp_idx == 2) ? 0 : exp_idx + 1;
    endtask

    // Checks one whole frame starting at bit 0; detector flag = odd parity at bit 2.
    task automatic expect_frame(input logic [2:0] bits, input logic exp_idle, input logic flag,
                                input int level, input int sent, input string tag);
        logic p;
        p = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk({tag, " bit_idx"}, 32'(bit_idx), 32'(b));
            chk({tag, " frame_start"}, 32'(frame_start), 32'(b == 0));
            chk({tag, " ser_out"}, 32'(ser_out), 32'(bits[2-b]));
            chk({tag, " idle_frame"}, 32'(idle_frame), 32'(exp_idle));
            chk({tag, " fifo_level"}, 32'(fifo_level), 32'(level));
            chk({tag, " sent_count"}, 32'(sent_count), 32'(sent));
            p = p ^ ser_out;
            if (b == 2) chk({tag, " detector"}, 32'(p), 32'(flag));
            tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 2'b00;
        in_mark  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_idx = 0;

        // Reset state and nine idle cycles
        chk("rst in_ready", 32'(in_ready), 32'd1);
        for (int t = 0; t < 9; t++) begin
            chk("idle ser_out", 32'(ser_out), 32'd0);
            chk("idle frame_start", 32'(frame_start), 32'(t % 3 == 0));
            chk("idle idle_frame", 32'(idle_frame), 32'd1);
            chk("idle sent_count", 32'(sent_count), 32'd0);
            chk("idle fifo_level", 32'(fifo_level), 32'd0);
            tick();
        end

        // Single mark frame pushed at bit 0
        in_valid = 1'b1; in_data = 2'b01; in_mark = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("w01 level", 32'(fifo_level), 32'd1);
        chk("w01 still idle", 32'(idle_frame), 32'd1);
        tick(); tick();
        expect_frame(3'b010, 1'b0, 1'b1, 0, 1, "w01m1");

        // Back-to-back pushes
        chk("b2b idle", 32'(idle_frame), 32'd1);
        in_valid = 1'b1; in_data = 2'b11; in_mark = 1'b0;
        tick();
        chk("b2b level1", 32'(fifo_level), 32'd1);
        in_data = 2'b11; in_mark = 1'b1;
        tick();
        chk("b2b level2", 32'(fifo_level), 32'd2);
        in_valid = 1'b0;
        tick();
        expect_frame(3'b110, 1'b0, 1'b0, 1, 2, "w11m0");
        expect_frame(3'b111, 1'b0, 1'b1, 0, 3, "w11m1");

        // Fill to full starting on a load edge; sixth word is held off
        tick(); tick();
        chk("full start idx", 32'(bit_idx), 32'd2);
        chk("full start ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 2'b10; in_mark = 1'b1;
        tick();
        chk("full l1", 32'(fifo_level), 32'd1);
        chk("full idle before w0", 32'(idle_frame), 32'd1);
        in_data = 2'b01; in_mark = 1'b0;
        tick();
        chk("full l2", 32'(fifo_level), 32'd2);
        in_data = 2'b00; in_mark = 1'b1;
        tick();
        chk("full l3", 32'(fifo_level), 32'd3);
        chk("full ready l3", 32'(in_ready), 32'd1);
        in_data = 2'b11; in_mark = 1'b1;
        tick();
        chk("full l3 push+pop", 32'(fifo_level), 32'd3);
        chk("w0 b0", 32'(ser_out), 32'd1);
        chk("w0 idle", 32'(idle_frame), 32'd0);
        chk("w0 sent", 32'(sent_count), 32'd4);
        in_data = 2'b10; in_mark = 1'b0;
        tick();
        chk("full l4", 32'(fifo_level), 32'd4);
        chk("full ready low", 32'(in_ready), 32'd0);
        chk("w0 b1", 32'(ser_out), 32'd0);
        in_data = 2'b01; in_mark = 1'b1;
        tick();
        chk("full held l4", 32'(fifo_level), 32'd4);
        chk("full held ready", 32'(in_ready), 32'd0);
        chk("w0 b2", 32'(ser_out), 32'd0);
        in_valid = 1'b0;
        tick();
        expect_frame(3'b011, 1'b0, 1'b0, 3, 5, "w1");
        expect_frame(3'b001, 1'b0, 1'b1, 2, 6, "w2");
        expect_frame(3'b111, 1'b0, 1'b1, 1, 7, "w3");
        expect_frame(3'b101, 1'b0, 1'b0, 0, 8, "w4");
        expect_frame(3'b000, 1'b1, 1'b0, 0, 8, "after full");

        // Push into empty FIFO on a load edge: no bypass
        tick(); tick();
        chk("nobypass idx", 32'(bit_idx), 32'd2);
        in_valid = 1'b1; in_data = 2'b01; in_mark = 1'b0;
        tick();
        in_valid = 1'b0;
        expect_frame(3'b000, 1'b1, 1'b0, 1, 8, "nobypass idle");
        expect_frame(3'b011, 1'b0, 1'b0, 0, 9, "nobypass data");

        // Reset mid-frame with three words queued
        in_valid = 1'b1; in_data = 2'b11; in_mark = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("pre-rst level", 32'(fifo_level), 32'd3);
        chk("pre-rst idx", 32'(bit_idx), 32'd1);
        chk("pre-rst sent", 32'(sent_count), 32'd10);
        chk("pre-rst ser_out", 32'(ser_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst ser_out", 32'(ser_out), 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst sent", 32'(sent_count), 32'd0);
        chk("rst ready", 32'(in_ready), 32'd1);
        chk("rst frame_start", 32'(frame_start), 32'd1);
        chk("rst idle", 32'(idle_frame), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_idx = 0;
        for (int f = 0; f < 3; f++) expect_frame(3'b000, 1'b1, 1'b0, 0, 0, "post-rst idle");

        // 256 mark frames: counter wraps to 0
        in_data = 2'b00; in_mark = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick(); tick();
            chk("wrap sent_count", 32'(sent_count), 32'((i + 1) % 256));
        end
        expect_frame(3'b001, 1'b0, 1'b1, 0, 0, "wrap last");
        expect_frame(3'b000, 1'b1, 1'b0, 0, 0, "wrap idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
